// File: rtl/decode_issue.sv
// RV32I ALU decode stage feeding a 2-entry skid buffer.
// The incoming bundle is decoded combinationally and queued; in_ready comes from registered state only.
module decode_issue (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_rs1_data,
   input  logic [31:0] in_rs2_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_A,
   output logic [31:0] out_B,
   output logic [3:0]  out_alu_op,
   output logic [4:0]  out_rd,
   output logic        out_reg_wr,
   output logic        out_illegal,
   output logic [1:0]  fsm_state
);

   // Handshake: a transfer happens on any rising edge where valid && ready;
   // the producer holds valid and data until that edge, and ready never waits on valid.
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   localparam logic [3:0] OP_NOP  = 4'd0,  OP_ADD  = 4'd1,  OP_SUB = 4'd2,
                          OP_XOR  = 4'd3,  OP_OR   = 4'd4,  OP_AND = 4'd5,
                          OP_SLT  = 4'd6,  OP_SLTU = 4'd7,  OP_SRL = 4'd8,
                          OP_SRA  = 4'd9,  OP_SLL  = 4'd10, OP_PASS_B = 4'd11;

   state_t      cur, nxt;
   logic        in_fire, out_fire;
   logic [74:0] dec, head, tail;

   logic [6:0]  opcode, f7;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_u, dec_a, dec_b;
   logic [3:0]  dec_op;
   logic        legal;

   assign opcode = in_instr[6:0];
   assign f3     = in_instr[14:12];
   assign f7     = in_instr[31:25];
   assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_u  = {in_instr[31:12], 12'b0};

   always_comb begin
      dec_op = OP_NOP;
      dec_a  = '0;
      dec_b  = '0;
      legal  = 1'b0;
      case (opcode)
         7'b0110011: begin
            legal = 1'b1;
            dec_a = in_rs1_data;
            dec_b = in_rs2_data;
            case (f3)
               3'b000: if (f7 == 7'b0000000) dec_op = OP_ADD;
                       else if (f7 == 7'b0100000) dec_op = OP_SUB;
                       else legal = 1'b0;
               3'b001: begin dec_op = OP_SLL; dec_b = {27'b0, in_rs2_data[4:0]}; end
               3'b010: dec_op = OP_SLT;
               3'b011: dec_op = OP_SLTU;
               3'b100: dec_op = OP_XOR;
               3'b101: begin
                  dec_b = {27'b0, in_rs2_data[4:0]};
                  if (f7 == 7'b0000000) dec_op = OP_SRL;
                  else if (f7 == 7'b0100000) dec_op = OP_SRA;
                  else legal = 1'b0;
               end
               3'b110: dec_op = OP_OR;
               3'b111: dec_op = OP_AND;
            endcase
         end
         7'b0010011: begin
            legal = 1'b1;
            dec_a = in_rs1_data;
            dec_b = imm_i;
            case (f3)
               3'b000: dec_op = OP_ADD;
               3'b001: begin
                  dec_b = {27'b0, in_instr[24:20]};
                  if (f7 == 7'b0000000) dec_op = OP_SLL;
                  else legal = 1'b0;
               end
               3'b010: dec_op = OP_SLT;
               3'b011: dec_op = OP_SLTU;
               3'b100: dec_op = OP_XOR;
               3'b101: begin
                  dec_b = {27'b0, in_instr[24:20]};
                  if (f7 == 7'b0000000) dec_op = OP_SRL;
                  else if (f7 == 7'b0100000) dec_op = OP_SRA;
                  else legal = 1'b0;
               end
               3'b110: dec_op = OP_OR;
               3'b111: dec_op = OP_AND;
            endcase
         end
         7'b0110111: begin legal = 1'b1; dec_op = OP_PASS_B; dec_b = imm_u; end
         7'b0010111: begin legal = 1'b1; dec_op = OP_ADD; dec_a = in_pc; dec_b = imm_u; end
         default: legal = 1'b0;
      endcase
      // Illegal bundles carry no operands so execute sees a clean NOP.
      if (!legal) begin
         dec_op = OP_NOP;
         dec_a  = '0;
         dec_b  = '0;
      end
   end

   assign dec = {dec_a, dec_b, dec_op, in_instr[11:7],
                 legal && (in_instr[11:7] != 5'd0), !legal};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cur <= EMPTY;
      else      cur <= nxt;
   end

   always_comb begin
      nxt = cur;
      if (flush) nxt = EMPTY;
      else begin
         case (cur)
            EMPTY:   if (in_fire) nxt = ONE;
            ONE:     if (in_fire && !out_fire) nxt = TWO;
                     else if (!in_fire && out_fire) nxt = EMPTY;
            TWO:     if (out_fire) nxt = ONE;
            default: nxt = EMPTY;
         endcase
      end
   end

   always_comb begin
      in_ready  = (cur != TWO);
      out_valid = (cur != EMPTY);
      in_fire   = in_valid && in_ready;
      out_fire  = out_valid && out_ready;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head <= '0;
         tail <= '0;
      end else if (!flush) begin
         case (cur)
            EMPTY: if (in_fire) head <= dec;
            ONE:   if (in_fire && out_fire) head <= dec;
                   else if (in_fire) tail <= dec;
            TWO:   if (out_fire) head <= tail;
            default: ;
         endcase
      end
   end

   assign {out_A, out_B, out_alu_op, out_rd, out_reg_wr, out_illegal} = head;
   assign fsm_state = cur;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed decode vectors, backpressure, flush, reset and a
// randomized run scored against a queue-based reference model.
module tb_decode_issue;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_reg_wr, out_illegal;
  logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data, out_A, out_B;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic [1:0]  fsm_state;

  int errors = 0;
  int checks = 0;
  logic [74:0] exp_q[$];

  // alu_op per funct3 for the shared R/I map, funct3 7 in the top nibble.
  localparam logic [31:0] F3_OPS = {4'd5, 4'd4, 4'd8, 4'd3, 4'd7, 4'd6, 4'd10, 4'd1};

  always #5 clk = ~clk;

  decode_issue dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_A(out_A), .out_B(out_B),
    .out_alu_op(out_alu_op), .out_rd(out_rd), .out_reg_wr(out_reg_wr),
    .out_illegal(out_illegal), .fsm_state(fsm_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [74:0] act();
    return {out_A, out_B, out_alu_op, out_rd, out_reg_wr, out_illegal};
  endfunction

  function automatic logic [74:0] model(input logic [31:0] instr, pc, rs1, rs2);
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b;
    logic [3:0]  op;
    logic        legal, shift;
    f3 = instr[14:12];
    f7 = instr[31:25];
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    a = 0; b = 0; op = 0; legal = 0;
    if (instr[6:0] == 7'h33) begin
      a = rs1;
      b = shift ? (rs2 & 32'd31) : rs2;
      op = F3_OPS[{f3, 2'b00} +: 4];
      legal = (f3 == 3'd0 || f3 == 3'd5) ? (f7 == 7'd0 || f7 == 7'd32) : 1'b1;
      if (f7 == 7'd32 && f3 == 3'd0) op = 4'd2;
      if (f7 == 7'd32 && f3 == 3'd5) op = 4'd9;
    end else if (instr[6:0] == 7'h13) begin
      a = rs1;
      b = shift ? {27'd0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
      op = F3_OPS[{f3, 2'b00} +: 4];
      legal = (f3 == 3'd1) ? (f7 == 7'd0) :
              (f3 == 3'd5) ? (f7 == 7'd0 || f7 == 7'd32) : 1'b1;
      if (f3 == 3'd5 && f7 == 7'd32) op = 4'd9;
    end else if (instr[6:0] == 7'h37) begin
      b = instr & 32'hFFFFF000; op = 4'd11; legal = 1;
    end else if (instr[6:0] == 7'h17) begin
      a = pc; b = instr & 32'hFFFFF000; op = 4'd1; legal = 1;
    end
    if (!legal) begin a = 0; b = 0; op = 0; end
    return {a, b, op, instr[11:7], legal && (instr[11:7] != 0), !legal};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 4);
    case (k)
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h37;
      3: w[6:0] = 7'h17;
      default: if (w[6:0] == 7'h33) w[6:0] = 7'h03;
    endcase
    if (w[6:0] == 7'h33) begin
      if (w[14:12] == 3'd0 || w[14:12] == 3'd5) begin
        k = $urandom_range(0, 2);
        if (k == 0) w[31:25] = 7'd0; else if (k == 1) w[31:25] = 7'd32;
      end else w[31:25] = 7'd0;
    end else if (w[6:0] == 7'h13 && (w[14:12] == 3'd1 || w[14:12] == 3'd5)) begin
      k = $urandom_range(0, 2);
      if (k == 0) w[31:25] = 7'd0; else if (k == 1) w[31:25] = 7'd32;
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, p, r1, r2);
    in_instr = i; in_pc = p; in_rs1_data = r1; in_rs2_data = r2;
  endtask

  task automatic test_reset();
    rst = 0; flush = 0; in_valid = 0; out_ready = 0;
    drive(32'h402081B3, 32'h40, 32'd1, 32'd2);
    #1;
    checks++;
    if (out_valid !== 1'b0 || act() !== 75'd0) begin
      errors++; $display("FAIL reset_outputs: valid=%b fields=%h required 0", out_valid, act());
    end
    tick(); tick();
    rst = 1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vi[9], vp[9], v1[9], v2[9];
    logic [74:0] ve[9];
    vi[0] = 32'h402081B3; vp[0] = 0;      v1[0] = 10;           v2[0] = 3;
    ve[0] = {32'd10, 32'd3, 4'd2, 5'd3, 1'b1, 1'b0};
    vi[1] = 32'h40435293; vp[1] = 0;      v1[1] = 32'h80000000; v2[1] = 32'h55;
    ve[1] = {32'h80000000, 32'd4, 4'd9, 5'd5, 1'b1, 1'b0};
    vi[2] = 32'h0020D233; vp[2] = 0;      v1[2] = 32'h1234;     v2[2] = 32'hFFFFFF21;
    ve[2] = {32'h1234, 32'd1, 4'd8, 5'd4, 1'b1, 1'b0};
    vi[3] = 32'h123453B7; vp[3] = 0;      v1[3] = 32'hDEAD;     v2[3] = 32'hBEEF;
    ve[3] = {32'd0, 32'h12345000, 4'd11, 5'd7, 1'b1, 1'b0};
    vi[4] = 32'h00001097; vp[4] = 32'h100; v1[4] = 32'h77;      v2[4] = 32'h88;
    ve[4] = {32'h100, 32'h1000, 4'd1, 5'd1, 1'b1, 1'b0};
    vi[5] = 32'h00012083; vp[5] = 0;      v1[5] = 5;            v2[5] = 6;
    ve[5] = {32'd0, 32'd0, 4'd0, 5'd1, 1'b0, 1'b1};
    vi[6] = 32'h00508013; vp[6] = 0;      v1[6] = 9;            v2[6] = 4;
    ve[6] = {32'd9, 32'd5, 4'd1, 5'd0, 1'b0, 1'b0};
    vi[7] = 32'h40309113; vp[7] = 0;      v1[7] = 3;            v2[7] = 4;
    ve[7] = {32'd0, 32'd0, 4'd0, 5'd2, 1'b0, 1'b1};
    vi[8] = 32'hFFF00413; vp[8] = 0;      v1[8] = 7;            v2[8] = 1;
    ve[8] = {32'd7, 32'hFFFFFFFF, 4'd1, 5'd8, 1'b1, 1'b0};
    out_ready = 1;
    for (int k = 0; k < 9; k++) begin
      drive(vi[k], vp[k], v1[k], v2[k]);
      in_valid = 1;
      tick();
      in_valid = 0;
      checks++;
      if (out_valid !== 1'b1 || act() !== ve[k]) begin
        errors++;
        $display("FAIL directed_%0d: valid=%b fields=%h required 1 %h", k, out_valid, act(), ve[k]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL directed_drain_%0d: out_valid=%b required 0", k, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] bi[3], bp[3], b1[3], b2[3];
    logic [74:0] be[3];
    int idx, taken;
    for (int k = 0; k < 3; k++) begin
      bi[k] = gen_instr(); bp[k] = $urandom; b1[k] = $urandom; b2[k] = $urandom;
      be[k] = model(bi[k], bp[k], b1[k], b2[k]);
    end
    out_ready = 0;
    idx = 0; taken = 0;
    drive(bi[0], bp[0], b1[0], b2[0]);
    in_valid = 1;
    for (int c = 0; c < 5; c++) begin
      if (in_valid && in_ready) begin
        taken++;
        idx++;
      end
      tick();
      if (idx < 3) drive(bi[idx], bp[idx], b1[idx], b2[idx]);
      checks++;
      if (out_valid !== 1'b1 || act() !== be[0]) begin
        errors++; $display("FAIL stall_stable_%0d: valid=%b fields=%h required 1 %h", c, out_valid, act(), be[0]);
      end
    end
    checks++;
    if (taken != 2 || in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_accept: accepted=%0d in_ready=%b required 2/0", taken, in_ready);
    end
    in_valid = 0;
    out_ready = 1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_valid !== 1'b1 || act() !== be[k]) begin
        errors++; $display("FAIL drain_order_%0d: valid=%b fields=%h required 1 %h", k, out_valid, act(), be[k]);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 0;
    in_valid = 1;
    drive(32'h00108093, 0, 1, 2);
    tick();
    drive(32'h00210113, 0, 3, 4);
    tick();
    drive(32'h00318193, 0, 5, 6);
    flush = 1;
    tick();
    flush = 0;
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_two: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL flush_leak_%0d: out_valid=%b required 0", c, out_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    drive(32'h123453B7, 0, 1, 2);
    in_valid = 1;
    tick();
    drive(32'h40435293, 0, 32'h80000000, 0);
    rst = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || act() !== 75'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: valid=%b in_ready=%b fields=%h required 0/1/0", out_valid, in_ready, act());
    end
    in_valid = 0;
    tick();
    rst = 1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_release: valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    logic o_fire, i_fire;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (in_ready !== (exp_q.size() < 2) || out_valid !== (exp_q.size() > 0)) begin
        errors++;
        $display("FAIL rand_flags_%0d: in_ready=%b out_valid=%b required %b/%b", c, in_ready, out_valid,
                 exp_q.size() < 2, exp_q.size() > 0);
      end
      if (exp_q.size() > 0) begin
        checks++;
        if (act() !== exp_q[0]) begin
          errors++; $display("FAIL rand_head_%0d: fields=%h required %h", c, act(), exp_q[0]);
        end
      end
      drive(gen_instr(), $urandom, $urandom, $urandom);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      if (flush) exp_q.delete();
      else begin
        o_fire = (exp_q.size() > 0) && out_ready;
        i_fire = in_valid && (exp_q.size() < 2);
        if (o_fire) void'(exp_q.pop_front());
        if (i_fire) exp_q.push_back(model(in_instr, in_pc, in_rs1_data, in_rs2_data));
      end
      tick();
    end
    in_valid = 0;
    flush = 0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
